// File: rtl/ofmap_packer.sv
// ----------------------------------------------------------------------------
// ofmap_packer
// Collects output-feature-map elements from the PE array into a small
// circular store and emits them two at a time as double-width words to the
// AXI write path. A flush request drains every stored element. If an odd
// element is left over, it goes out as a word with a zero upper half, and the
// final word of the flush is marked with out_last.
//
// Ports
//   clk         : clock, rising edge
//   nrst        : asynchronous active-low reset
//   in_vld      : element from the PE array is valid
//   in_data     : element value (DATA_WIDTH)
//   in_rdy      : packer accepts an element this cycle
//   flush       : single-cycle request to drain all stored elements
//   out_data    : packed word, older element in the lower half
//   out_vld     : out_data holds a complete (or padded final) word
//   out_rdy     : AXI side accepts the word
//   out_last    : current word is the final word of a flush
//   flush_done  : one-cycle pulse when a flush has completed
//   level       : number of stored elements
// ----------------------------------------------------------------------------
module ofmap_packer #(
  parameter int unsigned DATA_WIDTH = 16,
  // Even power of two, at least 4. The pointers wrap naturally at DEPTH.
  parameter int unsigned DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      in_vld,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_rdy,
  input  logic                      flush,
  output logic [2*DATA_WIDTH-1:0]   out_data,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic                      out_last,
  output logic                      flush_done,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_flush_done;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic [DATA_WIDTH-1:0] r_store [DEPTH];

  logic                  w_drain;
  logic                  w_in_rdy;
  logic                  w_pad;
  logic                  w_out_vld;
  logic                  w_push;
  logic                  w_pop;
  logic [AW-1:0]         w_rd_ptr_p1;
  logic [AW-1:0]         w_rd_step;
  logic [LW-1:0]         w_pop_cnt;
  logic [LW-1:0]         w_level_nxt;

  // Handshake decode: everything below comes from registered state only.
  assign w_drain     = (r_state == DRAIN);
  assign w_in_rdy    = !w_drain && (r_level < LW'(DEPTH));
  // A single leftover element during a drain goes out zero-padded.
  assign w_pad       = w_drain && (r_level == LW'(1));
  assign w_out_vld   = (r_level >= LW'(2)) || w_pad;
  assign w_push      = in_vld && w_in_rdy;
  assign w_pop       = w_out_vld && out_rdy;
  assign w_rd_ptr_p1 = r_rd_ptr + AW'(1);
  assign w_rd_step   = w_pad ? AW'(1) : AW'(2);
  assign w_pop_cnt   = w_pop ? (w_pad ? LW'(1) : LW'(2)) : LW'(0);
  assign w_level_nxt = r_level + LW'(w_push) - w_pop_cnt;

  // Output word: lower half is the older element; pairs across the wrap read
  // naturally because the pointer arithmetic is modulo DEPTH.
  always_comb begin
    out_data                         = '0;
    out_data[DATA_WIDTH-1:0]         = r_store[r_rd_ptr];
    out_data[2*DATA_WIDTH-1:DATA_WIDTH] = w_pad ? '0 : r_store[w_rd_ptr_p1];
  end

  assign in_rdy     = w_in_rdy;
  assign out_vld    = w_out_vld;
  assign out_last   = w_drain && (r_level <= LW'(2)) && w_out_vld;
  assign flush_done = r_flush_done;
  assign level      = r_level;

  // Flush FSM: DRAIN ends the cycle after the store has emptied, and that
  // transition is flagged by a one-cycle flush_done pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= IDLE;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (flush) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_level == LW'(0)) begin
            r_state      <= IDLE;
            r_flush_done <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + w_rd_step;
      end
      r_level <= w_level_nxt;
    end
  end

  // Element store; contents are not reset, the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_store[r_wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_ofmap_packer.sv
// ----------------------------------------------------------------------------
// tb_ofmap_packer
// Self-checking bench for ofmap_packer (DATA_WIDTH=16, DEPTH=8). A queue
// scoreboard tracks every accepted element and is popped as words leave the
// DUT. Each scenario task also checks its own key points inline.
// ----------------------------------------------------------------------------
module tb_ofmap_packer;

  localparam int unsigned DW = 16;
  localparam int unsigned DP = 8;

  logic          clk;
  logic          nrst;
  logic          in_vld;
  logic [DW-1:0] in_data;
  logic          in_rdy;
  logic          flush;
  logic [2*DW-1:0] out_data;
  logic          out_vld;
  logic          out_rdy;
  logic          out_last;
  logic          flush_done;
  logic [3:0]    level;

  int checks = 0;
  int errors = 0;
  int dut_words = 0;

  ofmap_packer #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_vld     (in_vld),
    .in_data    (in_data),
    .in_rdy     (in_rdy),
    .flush      (flush),
    .out_data   (out_data),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_last   (out_last),
    .flush_done (flush_done),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard model ----------------
  logic [DW-1:0]   m_q[$];
  logic            m_drain = 1'b0;
  logic            m_fd    = 1'b0;
  logic            e_vld;
  logic            e_pad;
  logic            e_last;
  logic            e_rdy;
  logic [2*DW-1:0] e_word;
  logic            n_push;
  logic            n_pop;
  int              cur_size;

  always @(negedge clk) begin
    if (!nrst) begin
      m_q.delete();
      m_drain = 1'b0;
      m_fd    = 1'b0;
    end
    cur_size = m_q.size();
    e_pad  = m_drain && (cur_size == 1);
    e_vld  = (cur_size >= 2) || e_pad;
    e_last = m_drain && (cur_size <= 2) && e_vld;
    e_rdy  = !m_drain && (cur_size < DP);

    checks++;
    if (out_vld !== e_vld) begin
      errors++;
      $display("FAIL sb_out_vld t=%0t got %b exp %b", $time, out_vld, e_vld);
    end
    checks++;
    if (level !== 4'(cur_size)) begin
      errors++;
      $display("FAIL sb_level t=%0t got %0d exp %0d", $time, level, cur_size);
    end
    checks++;
    if (in_rdy !== e_rdy) begin
      errors++;
      $display("FAIL sb_in_rdy t=%0t got %b exp %b", $time, in_rdy, e_rdy);
    end
    checks++;
    if (out_last !== e_last) begin
      errors++;
      $display("FAIL sb_out_last t=%0t got %b exp %b", $time, out_last, e_last);
    end
    checks++;
    if (flush_done !== m_fd) begin
      errors++;
      $display("FAIL sb_flush_done t=%0t got %b exp %b", $time, flush_done, m_fd);
    end
    if (e_vld) begin
      e_word = e_pad ? {16'h0000, m_q[0]} : {m_q[1], m_q[0]};
      checks++;
      if (out_data !== e_word) begin
        errors++;
        $display("FAIL sb_out_data t=%0t got %h exp %h", $time, out_data, e_word);
      end
    end

    if (nrst) begin
      if (out_vld && out_rdy) dut_words++;
      n_push = in_vld && e_rdy;
      n_pop  = e_vld && out_rdy;
      if (n_pop) begin
        void'(m_q.pop_front());
        if (!e_pad) void'(m_q.pop_front());
      end
      if (n_push) m_q.push_back(in_data);
      m_fd = m_drain && (cur_size == 0);
      if (!m_drain) m_drain = flush;
      else          m_drain = (cur_size != 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; in_vld = 1'b0; in_data = '0; flush = 1'b0; out_rdy = 1'b0;
    step(); step();
    checks++;
    if (out_vld !== 1'b0 || level !== 4'd0 || flush_done !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got vld=%b lvl=%0d fd=%b last=%b exp 0/0/0/0",
               out_vld, level, flush_done, out_last);
    end
    nrst = 1'b1;
    step();
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_rdy got %b exp 1", in_rdy);
    end
  endtask

  task automatic test_pair();
    out_rdy = 1'b1;
    in_vld = 1'b1; in_data = 16'h0001; step();
    checks++;
    if (out_vld !== 1'b0 || level !== 4'd1) begin
      errors++;
      $display("FAIL pair_first got vld=%b lvl=%0d exp 0/1", out_vld, level);
    end
    in_data = 16'h0002; step();
    in_vld = 1'b0;
    checks++;
    if (out_vld !== 1'b1 || out_data !== 32'h0002_0001) begin
      errors++;
      $display("FAIL pair_word got vld=%b data=%h exp 1/00020001", out_vld, out_data);
    end
    step();
    checks++;
    if (level !== 4'd0 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL pair_empty got lvl=%0d vld=%b exp 0/0", level, out_vld);
    end
  endtask

  task automatic test_full();
    logic [2*DW-1:0] exp;
    out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_vld = 1'b1; in_data = 16'(16'h0010 + i); step();
    end
    checks++;
    if (level !== 4'd8 || in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL full_level got lvl=%0d rdy=%b exp 8/0", level, in_rdy);
    end
    in_data = 16'h0099; step();
    in_vld = 1'b0;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (level !== 4'd8 || out_data !== 32'h0011_0010) begin
        errors++;
        $display("FAIL full_stall got lvl=%0d data=%h exp 8/00110010", level, out_data);
      end
      step();
    end
    out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp = {16'(16'h0011 + 2 * k), 16'(16'h0010 + 2 * k)};
      checks++;
      if (out_vld !== 1'b1 || out_data !== exp) begin
        errors++;
        $display("FAIL full_drain_%0d got vld=%b data=%h exp 1/%h", k, out_vld, out_data, exp);
      end
      step();
    end
    checks++;
    if (level !== 4'd0) begin
      errors++;
      $display("FAIL full_end got lvl=%0d exp 0", level);
    end
    out_rdy = 1'b0;
  endtask

  task automatic test_flush_odd();
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = 16'h000A; step();
    in_data = 16'h000B; step();
    in_data = 16'h000C; step();
    in_vld = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    checks++;
    if (in_rdy !== 1'b0 || out_data !== 32'h000B_000A || out_last !== 1'b0) begin
      errors++;
      $display("FAIL flush_w0 got rdy=%b data=%h last=%b exp 0/000b000a/0", in_rdy, out_data, out_last);
    end
    // Inputs offered during the drain must be ignored.
    in_vld = 1'b1; in_data = 16'h00EE; flush = 1'b1; out_rdy = 1'b1; step();
    flush = 1'b0;
    checks++;
    if (in_rdy !== 1'b0 || out_data !== 32'h0000_000C || out_last !== 1'b1 || out_vld !== 1'b1) begin
      errors++;
      $display("FAIL flush_w1 got rdy=%b vld=%b data=%h last=%b exp 0/1/0000000c/1",
               in_rdy, out_vld, out_data, out_last);
    end
    step();
    in_vld = 1'b0;
    checks++;
    if (out_vld !== 1'b0 || flush_done !== 1'b0 || in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty got vld=%b fd=%b rdy=%b exp 0/0/0", out_vld, flush_done, in_rdy);
    end
    step();
    checks++;
    if (flush_done !== 1'b1 || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL flush_done_pulse got fd=%b rdy=%b exp 1/1", flush_done, in_rdy);
    end
    step();
    checks++;
    if (flush_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_done_width got %b exp 0", flush_done);
    end
    out_rdy = 1'b0;
  endtask

  task automatic test_empty_flush();
    out_rdy = 1'b1;
    flush = 1'b1; step();
    flush = 1'b0;
    checks++;
    if (out_vld !== 1'b0 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL eflush_c1 got vld=%b fd=%b exp 0/0", out_vld, flush_done);
    end
    step();
    checks++;
    if (out_vld !== 1'b0 || flush_done !== 1'b1) begin
      errors++;
      $display("FAIL eflush_c2 got vld=%b fd=%b exp 0/1", out_vld, flush_done);
    end
    step();
    out_rdy = 1'b0;
  endtask

  task automatic test_wrap_round(input int n);
    int w0;
    int cnt;
    w0 = dut_words;
    for (int i = 0; i < n; i++) begin
      in_vld  = 1'b1;
      in_data = 16'($urandom);
      out_rdy = i[0];
      step();
    end
    in_vld = 1'b0; out_rdy = 1'b0; flush = 1'b1; step();
    flush = 1'b0; out_rdy = 1'b1;
    cnt = 0;
    while (flush_done !== 1'b1 && cnt < 40) begin
      step();
      cnt++;
    end
    checks++;
    if (flush_done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_flush_timeout got fd=%b exp 1", flush_done);
    end
    checks++;
    if (dut_words - w0 != (n + 1) / 2) begin
      errors++;
      $display("FAIL wrap_word_count got %0d exp %0d", dut_words - w0, (n + 1) / 2);
    end
    step();
    out_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1; in_data = 16'(16'h0040 + i); step();
    end
    in_vld = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    checks++;
    if (level !== 4'd5 || in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_pre got lvl=%0d rdy=%b exp 5/0", level, in_rdy);
    end
    nrst = 1'b0;
    #2;
    checks++;
    if (out_vld !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL rmid_reset got vld=%b lvl=%0d exp 0/0", out_vld, level);
    end
    step();
    nrst = 1'b1;
    out_rdy = 1'b1;
    step();
    checks++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL rmid_idle got rdy=%b vld=%b exp 1/0", in_rdy, out_vld);
    end
    in_vld = 1'b1; in_data = 16'h0055; step();
    in_data = 16'h0066; step();
    in_vld = 1'b0;
    checks++;
    if (out_vld !== 1'b1 || out_data !== 32'h0066_0055) begin
      errors++;
      $display("FAIL rmid_word got vld=%b data=%h exp 1/00660055", out_vld, out_data);
    end
    step();
    out_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pair();
    test_full();
    test_flush_odd();
    test_empty_flush();
    test_wrap_round(33);
    test_wrap_round(33);
    test_reset_mid();
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
